// File: rtl/router_rx_client.sv
// router_rx_client: destination-side packet consumer for one router port.
// Reads the output FIFO, reassembles {header, payload, parity} and keeps stats.
//
// Ports:
//   clock, resetn        rising-edge clock, asynchronous active-low reset
//   vld_out              FIFO non-empty
//   data_out[7:0]        FIFO read data, valid the cycle after a read_enb sample
//   soft_reset           FIFO of this port is being flushed; abandon the packet
//   rd_delay[5:0]        cycles to wait with vld_out high before the first read
//   read_enb             FIFO read enable (combinational)
//   busy                 any state other than IDLE
//   pkt_done             one-cycle pulse when a packet has been fully consumed
//   parity_err/addr_err  error flags, pulsed together with pkt_done
//   drop                 one-cycle pulse when a packet is abandoned
//   last_hdr, pkt_len    header and payload length of the last completed packet
//   pkt_cnt, err_cnt     saturating completed / errored packet counters
module router_rx_client #(
    parameter logic [1:0]  PORT_ADDR = 2'd0,
    parameter int unsigned CNT_W     = 16
) (
    input  logic             clock,
    input  logic             resetn,
    input  logic             vld_out,
    input  logic [7:0]       data_out,
    input  logic             soft_reset,
    input  logic [5:0]       rd_delay,
    output logic             read_enb,
    output logic             busy,
    output logic             pkt_done,
    output logic             parity_err,
    output logic             addr_err,
    output logic             drop,
    output logic [7:0]       last_hdr,
    output logic [5:0]       pkt_len,
    output logic [CNT_W-1:0] pkt_cnt,
    output logic [7:0]       err_cnt
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_WAIT,
        S_HDR_REQ,
        S_HDR_CAP,
        S_PAYLOAD,
        S_DONE
    } state_t;

    state_t           state_q, state_d;
    logic             rd_q;
    logic [5:0]       wcnt_q, wcnt_d;
    logic [7:0]       hdr_q, hdr_d;
    logic [7:0]       xacc_q, xacc_d;
    // rem counts payload bytes plus the parity byte, so it needs 7 bits
    logic [6:0]       rem_q, rem_d;
    logic [6:0]       issued_q, issued_d;
    logic [6:0]       capd_q, capd_d;
    logic             perr_q, perr_d;
    logic [7:0]       last_hdr_q, last_hdr_d;
    logic [5:0]       pkt_len_q, pkt_len_d;
    logic [CNT_W-1:0] pkt_cnt_q, pkt_cnt_d;
    logic [7:0]       err_cnt_q, err_cnt_d;
    logic             rd_en;
    logic             aerr;

    always_comb begin
        state_d    = state_q;
        wcnt_d     = wcnt_q;
        hdr_d      = hdr_q;
        xacc_d     = xacc_q;
        rem_d      = rem_q;
        issued_d   = issued_q;
        capd_d     = capd_q;
        perr_d     = perr_q;
        last_hdr_d = last_hdr_q;
        pkt_len_d  = pkt_len_q;
        pkt_cnt_d  = pkt_cnt_q;
        err_cnt_d  = err_cnt_q;
        rd_en      = 1'b0;
        pkt_done   = 1'b0;
        parity_err = 1'b0;
        addr_err   = 1'b0;
        drop       = 1'b0;
        aerr       = (hdr_q[1:0] != PORT_ADDR);

        unique case (state_q)
            S_IDLE: begin
                if (vld_out) begin
                    wcnt_d  = 6'd0;
                    state_d = S_WAIT;
                end
            end
            S_WAIT: begin
                if (soft_reset) begin
                    drop    = 1'b1;
                    state_d = S_IDLE;
                end else begin
                    wcnt_d = (&wcnt_q) ? wcnt_q : wcnt_q + 6'd1;
                    if (wcnt_q >= rd_delay) begin
                        state_d = S_HDR_REQ;
                    end
                end
            end
            S_HDR_REQ: begin
                if (soft_reset) begin
                    drop    = 1'b1;
                    state_d = S_IDLE;
                end else begin
                    rd_en = vld_out;
                    if (vld_out) begin
                        state_d = S_HDR_CAP;
                    end
                end
            end
            S_HDR_CAP: begin
                // no read here: this is the bubble between header and payload
                if (soft_reset) begin
                    drop    = 1'b1;
                    state_d = S_IDLE;
                end else if (rd_q) begin
                    hdr_d    = data_out;
                    xacc_d   = data_out;
                    rem_d    = {1'b0, data_out[7:2]} + 7'd1;
                    issued_d = 7'd0;
                    capd_d   = 7'd0;
                    state_d  = S_PAYLOAD;
                end
            end
            S_PAYLOAD: begin
                if (soft_reset) begin
                    drop    = 1'b1;
                    state_d = S_IDLE;
                end else begin
                    rd_en = vld_out && (issued_q < rem_q);
                    if (rd_en) begin
                        issued_d = issued_q + 7'd1;
                    end
                    if (rd_q) begin
                        capd_d = capd_q + 7'd1;
                        // the last byte captured is parity, not payload
                        if (capd_q == rem_q - 7'd1) begin
                            perr_d  = (xacc_q != data_out);
                            state_d = S_DONE;
                        end else begin
                            xacc_d = xacc_q ^ data_out;
                        end
                    end
                end
            end
            S_DONE: begin
                pkt_done   = 1'b1;
                parity_err = perr_q;
                addr_err   = aerr;
                last_hdr_d = hdr_q;
                pkt_len_d  = hdr_q[7:2];
                pkt_cnt_d  = (&pkt_cnt_q) ? pkt_cnt_q
                                          : pkt_cnt_q + CNT_W'(1);
                if (perr_q || aerr) begin
                    err_cnt_d = (&err_cnt_q) ? err_cnt_q
                                             : err_cnt_q + 8'd1;
                end
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            state_q    <= S_IDLE;
            rd_q       <= 1'b0;
            wcnt_q     <= '0;
            hdr_q      <= '0;
            xacc_q     <= '0;
            rem_q      <= '0;
            issued_q   <= '0;
            capd_q     <= '0;
            perr_q     <= 1'b0;
            last_hdr_q <= '0;
            pkt_len_q  <= '0;
            pkt_cnt_q  <= '0;
            err_cnt_q  <= '0;
        end else begin
            state_q    <= state_d;
            rd_q       <= rd_en;
            wcnt_q     <= wcnt_d;
            hdr_q      <= hdr_d;
            xacc_q     <= xacc_d;
            rem_q      <= rem_d;
            issued_q   <= issued_d;
            capd_q     <= capd_d;
            perr_q     <= perr_d;
            last_hdr_q <= last_hdr_d;
            pkt_len_q  <= pkt_len_d;
            pkt_cnt_q  <= pkt_cnt_d;
            err_cnt_q  <= err_cnt_d;
        end
    end

    assign read_enb = rd_en;
    assign busy     = (state_q != S_IDLE);
    assign last_hdr = last_hdr_q;
    assign pkt_len  = pkt_len_q;
    assign pkt_cnt  = pkt_cnt_q;
    assign err_cnt  = err_cnt_q;

endmodule

// File: tb/tb_router_rx_client.sv
// tb_router_rx_client: scoreboard bench for router_rx_client.
// A FIFO model feeds packets; expected results are queued per packet.
module tb_router_rx_client;

    localparam logic [1:0] PA = 2'd0;

    typedef struct packed {
        logic [7:0] hdr;
        logic       perr;
        logic       aerr;
        logic [7:0] stall;
    } exp_t;

    logic        clock;
    logic        resetn;
    logic        vld_out;
    logic [7:0]  data_out;
    logic        soft_reset;
    logic [5:0]  rd_delay;
    logic        read_enb;
    logic        busy;
    logic        pkt_done;
    logic        parity_err;
    logic        addr_err;
    logic        drop;
    logic [7:0]  last_hdr;
    logic [5:0]  pkt_len;
    logic [15:0] pkt_cnt;
    logic [7:0]  err_cnt;

    router_rx_client #(.PORT_ADDR(PA), .CNT_W(16)) u_dut (
        .clock      (clock),
        .resetn     (resetn),
        .vld_out    (vld_out),
        .data_out   (data_out),
        .soft_reset (soft_reset),
        .rd_delay   (rd_delay),
        .read_enb   (read_enb),
        .busy       (busy),
        .pkt_done   (pkt_done),
        .parity_err (parity_err),
        .addr_err   (addr_err),
        .drop       (drop),
        .last_hdr   (last_hdr),
        .pkt_len    (pkt_len),
        .pkt_cnt    (pkt_cnt),
        .err_cnt    (err_cnt)
    );

    logic [7:0] fifo[$];
    exp_t       exp_q[$];

    int n_vec  = 0;
    int n_miss = 0;

    // monitor state
    bit         pend      = 0;
    int         cyc       = 0;
    int         rds       = 0;
    int         c1        = 0;
    int         c2        = 0;
    int         c_last    = 0;
    int         stall_at  = 0;
    int         stall_cnt = 0;
    int         bad_rd    = 0;
    int         drops     = 0;
    bit         reg_pend  = 0;
    logic [7:0] reg_hdr   = 8'h00;
    int         m_cnt     = 0;
    int         m_err     = 0;

    task automatic check(input string tag, input logic [63:0] got,
                         input logic [63:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_miss++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    initial begin
        clock = 1'b0;
        forever #5 clock = ~clock;
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    // FIFO model and output monitor, both acting on the falling edge
    initial begin
        exp_t e;
        vld_out  = 1'b0;
        data_out = 8'h00;
        forever begin
            @(negedge clock);
            if (!resetn) begin
                pend      = 0;
                rds       = 0;
                stall_cnt = 0;
                reg_pend  = 0;
                vld_out   = 1'b0;
                continue;
            end
            if (pend) begin
                data_out = fifo.pop_front();
                pend     = 0;
            end
            if (stall_cnt > 0) begin
                vld_out = 1'b0;
                stall_cnt--;
            end else begin
                vld_out = (fifo.size() > 0);
            end
            #1;
            cyc++;
            if (reg_pend) begin
                reg_pend = 0;
                check("last_hdr", 64'(last_hdr), 64'(reg_hdr));
                check("pkt_len", 64'(pkt_len), 64'(reg_hdr[7:2]));
                check("pkt_cnt", 64'(pkt_cnt), 64'(m_cnt));
                check("err_cnt", 64'(err_cnt), 64'(m_err));
            end
            if (read_enb) begin
                pend = 1;
                rds++;
                if (rds == 1) c1 = cyc;
                if (rds == 2) c2 = cyc;
                c_last = cyc;
                if (!vld_out) bad_rd++;
                if (stall_at != 0 && rds == stall_at) stall_cnt = 3;
            end
            if (drop) drops++;
            if (pkt_done) begin
                if (exp_q.size() == 0) begin
                    check("spurious_done", 64'(exp_q.size()), 64'(1));
                end else begin
                    e = exp_q.pop_front();
                    check("parity_err", 64'(parity_err), 64'(e.perr));
                    check("addr_err", 64'(addr_err), 64'(e.aerr));
                    check("rd_in_done", 64'(read_enb), 64'(0));
                    check("reads", 64'(rds), 64'(e.hdr[7:2]) + 64'(2));
                    check("bubble", 64'(c2 - c1), 64'(2));
                    check("span", 64'(c_last - c1),
                          64'(e.hdr[7:2]) + 64'(2) + 64'(e.stall));
                    m_cnt++;
                    if (e.perr || e.aerr) m_err++;
                    reg_hdr  = e.hdr;
                    reg_pend = 1;
                end
                rds = 0;
            end
        end
    end

    task automatic tick();
        @(posedge clock);
        #2;
    endtask

    task automatic send(input logic [5:0] len, input logic [1:0] addr,
                        input bit bad, input bit fixed,
                        input logic [7:0] stall);
        logic [7:0] h;
        logic [7:0] p;
        logic [7:0] b;
        exp_t       e;
        h = {len, addr};
        p = h;
        fifo.push_back(h);
        for (int i = 0; i < int'(len); i++) begin
            if (fixed) b = 8'(8'h11 * (i + 1));
            else       b = 8'($urandom_range(0, 255));
            p ^= b;
            fifo.push_back(b);
        end
        if (bad) p ^= 8'h01;
        fifo.push_back(p);
        e.hdr   = h;
        e.perr  = bad;
        e.aerr  = (addr != PA);
        e.stall = stall;
        exp_q.push_back(e);
    endtask

    task automatic wait_idle(input int budget);
        for (int i = 0; i < budget; i++) begin
            tick();
            if (exp_q.size() == 0 && !busy && !reg_pend) break;
        end
        check("pending_pkts", 64'(exp_q.size()), 64'(0));
    endtask

    function automatic logic [63:0] outs();
        return 64'({read_enb, busy, pkt_done, parity_err, addr_err, drop,
                    last_hdr, pkt_len, pkt_cnt, err_cnt});
    endfunction

    initial begin
        resetn     = 1'b0;
        soft_reset = 1'b0;
        rd_delay   = 6'd0;
        repeat (3) tick();
        check("reset_outs", outs(), 64'(0));
        resetn = 1'b1;
        tick();

        // nominal packet 0C 11 22 33 0C
        send(6'd3, 2'd0, 1'b0, 1'b1, 8'd0);
        wait_idle(100);
        check("nominal_cnt", 64'(pkt_cnt), 64'(1));

        // same packet, parity 0D
        send(6'd3, 2'd0, 1'b1, 1'b1, 8'd0);
        wait_idle(100);
        check("badpar_err_cnt", 64'(err_cnt), 64'(1));
        check("badpar_pkt_cnt", 64'(pkt_cnt), 64'(2));

        // timeout: long delay, flush after 30 cycles
        rd_delay = 6'd40;
        fifo.push_back(8'h0C);
        fifo.push_back(8'h11);
        repeat (30) tick();
        check("to_no_read", 64'(rds), 64'(0));
        check("to_busy", 64'(busy), 64'(1));
        soft_reset = 1'b1;
        fifo.delete();
        tick();
        soft_reset = 1'b0;
        tick();
        check("to_drop", 64'(drops), 64'(1));
        check("to_idle", 64'(busy), 64'(0));
        check("to_pkt_cnt", 64'(pkt_cnt), 64'(2));
        check("to_no_read2", 64'(rds), 64'(0));
        rd_delay = 6'd0;

        // stall of 3 cycles after the 2nd payload byte
        stall_at = 3;
        send(6'd4, 2'd0, 1'b0, 1'b0, 8'd3);
        wait_idle(100);
        stall_at = 0;

        // zero-length packets: good address, then wrong address
        send(6'd0, 2'd0, 1'b0, 1'b0, 8'd0);
        wait_idle(100);
        check("len0_pkt_len", 64'(pkt_len), 64'(0));
        send(6'd0, 2'd2, 1'b0, 1'b0, 8'd0);
        wait_idle(100);

        // back-to-back random packets with a nonzero read delay
        rd_delay = 6'd5;
        for (int k = 0; k < 4; k++) begin
            send(6'($urandom_range(0, 20)), 2'($urandom_range(0, 3)),
                 1'($urandom_range(0, 1)), 1'b0, 8'd0);
        end
        wait_idle(800);
        rd_delay = 6'd0;

        // asynchronous reset in the middle of a payload
        send(6'd10, 2'd0, 1'b0, 1'b0, 8'd0);
        for (int i = 0; i < 100; i++) begin
            tick();
            if (rds >= 4) break;
        end
        check("mid_reached", 64'(rds >= 4), 64'(1));
        resetn = 1'b0;
        #1;
        check("async_reset_outs", outs(), 64'(0));
        fifo.delete();
        exp_q.delete();
        m_cnt = 0;
        m_err = 0;
        tick();
        tick();
        resetn = 1'b1;
        tick();
        send(6'd5, 2'd0, 1'b0, 1'b0, 8'd0);
        wait_idle(100);
        check("post_reset_cnt", 64'(pkt_cnt), 64'(1));

        check("read_without_vld", 64'(bad_rd), 64'(0));
        check("total_drops", 64'(drops), 64'(1));
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule

// File: doc/router_rx_client.md
Name: router_rx_client

Overview:
- Destination-side packet consumer for one output port of the 1x3 router.
- Sits across the router's output FIFO interface: watches vld_out_x, drives read_enb_x, and consumes data_out_x.
- Reassembles each packet (header, payload, parity), checks parity and destination address, and maintains statistics.
- Has a programmable read start delay, so bench and system can exercise the router's 30-cycle soft-reset timeout.

Parameters:
- PORT_ADDR, 2'd0, destination address this client expects in header[1:0].
- CNT_W, 16, width of the packet counter.

Ports:
- clock  in  1  system clock, rising edge.
- resetn  in  1  asynchronous active-low reset.
- vld_out  in  1  router output valid; FIFO non-empty.
- data_out  in  8  FIFO read data; valid the cycle after a read_enb high sample.
- soft_reset  in  1  router soft reset for this port; FIFO is being flushed.
- rd_delay  in  6  cycles to wait with vld_out high before the first read.
- read_enb  out  1  FIFO read enable.
- busy  out  1  high in any state other than IDLE.
- pkt_done  out  1  one-cycle pulse: packet fully consumed.
- parity_err  out  1  one-cycle pulse with pkt_done: parity mismatch.
- addr_err  out  1  one-cycle pulse with pkt_done: header[1:0] != PORT_ADDR.
- drop  out  1  one-cycle pulse: packet abandoned because soft_reset was seen.
- last_hdr  out  8  header of the last completed packet.
- pkt_len  out  6  payload length of the last completed packet.
- pkt_cnt  out  CNT_W  completed packets; saturates at all-ones.
- err_cnt  out  8  packets with parity_err or addr_err; saturates at 255.

Behaviour:
- Reset: resetn low asynchronously forces state to IDLE and clears every register. All outputs are 0 during and after reset.
- Packet format:
  - header = {len[5:0], addr[1:0]}.
  - Followed by len payload bytes (0..63), then one parity byte.
  - Parity byte = XOR of header and all payload bytes.
- read_enb timing: read_enb is combinational, = (state is HDR_REQ or PAYLOAD) && vld_out && (in PAYLOAD: issued < rem). It is never high while vld_out is low.
- Capture: rd_q is read_enb registered. data_out is captured only in cycles where rd_q = 1.
- FSM states: IDLE, WAIT, HDR_REQ, HDR_CAP, PAYLOAD, DONE.
- IDLE: on vld_out = 1, clear wcnt and go to WAIT.
- WAIT:
  - wcnt increments each cycle.
  - If soft_reset: pulse drop, go to IDLE.
  - Else if wcnt >= rd_delay: go to HDR_REQ.
  - With rd_delay = 0, read_enb first rises 2 cycles after vld_out rises.
- HDR_REQ: hold until read_enb = 1, then go to HDR_CAP.
- HDR_CAP (rd_q = 1):
  - hdr <= data_out; xacc <= data_out.
  - rem <= data_out[7:2] + 1, 7-bit (payload plus parity).
  - issued <= 0; capd <= 0; go to PAYLOAD.
  - read_enb is low in this cycle: one bubble between header and payload.
- PAYLOAD:
  - issued increments on each read_enb.
  - On each rd_q: capd increments.
  - If capd < rem-1 the byte is payload: xacc ^= data_out.
  - If capd == rem-1 the byte is parity: perr <= (xacc != data_out); go to DONE.
  - vld_out low mid-packet stalls reads without error; the counters simply hold.
- DONE, for one cycle:
  - pkt_done = 1; parity_err = perr; addr_err = (hdr[1:0] != PORT_ADDR).
  - last_hdr <= hdr; pkt_len <= hdr[7:2].
  - pkt_cnt++ and err_cnt++ (on error), both saturating.
  - Go to IDLE. A back-to-back packet is picked up the next cycle via IDLE.
- soft_reset in HDR_REQ, HDR_CAP or PAYLOAD: abort immediately, pulse drop, go to IDLE. read_enb is low that cycle; no counters change.
- len = 0: PAYLOAD issues exactly one read (the parity byte).
- read_enb and rd_q must never be high in IDLE, WAIT or DONE.

Test Plan:
- Nominal read, rd_delay = 0, PORT_ADDR = 0:
  - Stimulus: FIFO holds 0x0C, 0x11, 0x22, 0x33, 0x0C.
  - Required: read_enb high for 1 + 4 cycles with one bubble; pkt_done pulse; parity_err = 0, addr_err = 0; pkt_len = 3; last_hdr = 0x0C; pkt_cnt = 1.
- Bad parity:
  - Stimulus: same packet with parity byte 0x0D.
  - Required: parity_err pulses with pkt_done; err_cnt = 1; pkt_cnt = 2.
- Timeout:
  - Stimulus: rd_delay = 40; vld_out held; soft_reset asserted after 30 cycles.
  - Required: drop pulses; read_enb never rises; pkt_cnt unchanged; state returns to IDLE.
- Stall mid-payload:
  - Stimulus: vld_out low for 3 cycles after the 2nd payload byte.
  - Required: read_enb low for exactly those cycles; packet completes with parity_err = 0.
- len 0 and address check, PORT_ADDR = 1:
  - Stimulus: header 0x01, parity 0x01; then header 0x02, parity 0x02.
  - Required: first packet errors = 0, pkt_len = 0; second packet addr_err = 1.
- Reset mid-operation:
  - Stimulus: resetn low during PAYLOAD.
  - Required: all outputs 0 immediately (asynchronous). Next packet is read correctly from IDLE.
